// File: rtl/microc_pkg.sv
// Shared definitions for the microcontroller datapath: ALU operation codes
// and instruction field positions.
package microc_pkg;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_NOTA  = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_NEGA  = 3'b110;
  localparam logic [2:0] ALU_NEGB  = 3'b111;

  localparam int OPC_W   = 6;
  localparam int RA_W    = 4;
  localparam int RA1_LSB = 8;
  localparam int RA2_LSB = 4;
  localparam int WA3_LSB = 0;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of code addresses with occupancy flags and
// single-cycle overflow/underflow pulses. Push and pop together replace the top.
module ras_stack #(
  parameter int AW        = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_din,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [CW-1:0] r_count;
  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [CW-1:0] w_top_idx;
  logic [CW-1:0] w_wr_idx;
  logic          w_wr_en;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(RAS_DEPTH));
  assign o_unf     = i_pop & o_empty;
  assign o_ovf     = i_push & ~i_pop & o_full;
  assign w_top_idx = r_count - CW'(1);

  // A tail call (push with pop) overwrites the current top instead of growing.
  assign w_wr_en  = i_push & (i_pop ? ~o_empty : ~o_full);
  assign w_wr_idx = i_pop ? w_top_idx : r_count;

  always_comb begin
    o_top = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (w_top_idx == CW'(i)) o_top = r_mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_push && !i_pop && !o_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !i_push && !o_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (w_wr_en && (w_wr_idx == CW'(i))) r_mem[i] <= i_din;
    end
  end

endmodule

// File: rtl/microc_ras.sv
// Single-cycle microcontroller datapath with a return-address stack for
// nested calls, stack status flags and a sticky stack-error flag.
module microc_ras
  import microc_pkg::*;
#(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int IW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic          s_inc,
  input  logic          s_inm,
  input  logic          we3,
  input  logic          wez,
  input  logic [2:0]    op,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] pc,
  output logic [5:0]    opcode,
  output logic          z,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  logic [AW-1:0]   r_pc;
  logic            r_z;
  logic            r_err;
  logic [DW-1:0]   r_rf [16];

  logic [RA_W-1:0] w_ra1, w_ra2, w_wa3;
  logic [DW-1:0]   w_rd1, w_rd2, w_alu, w_imm, w_wd3;
  logic            w_zalu;
  logic [AW-1:0]   w_pc_inc, w_pc_nxt, w_target, w_top;
  logic            w_empty, w_full, w_ovf, w_unf;

  function automatic logic [DW-1:0] alu_f(input logic [2:0]    f_op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (f_op)
      ALU_PASSA: return a;
      ALU_NOTA:  return ~a;
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_NEGA:  return '0 - a;
      default:   return '0 - b;
    endcase
  endfunction

  assign w_ra1    = instr[RA1_LSB +: RA_W];
  assign w_ra2    = instr[RA2_LSB +: RA_W];
  assign w_wa3    = instr[WA3_LSB +: RA_W];
  assign w_imm    = instr[DW+3:4];
  assign w_target = instr[AW-1:0];

  // r0 is hard-wired to zero on read; its storage slot is never consulted.
  assign w_rd1  = (w_ra1 == '0) ? '0 : r_rf[w_ra1];
  assign w_rd2  = (w_ra2 == '0) ? '0 : r_rf[w_ra2];
  assign w_alu  = alu_f(op, w_rd1, w_rd2);
  assign w_zalu = (w_alu == '0);
  assign w_wd3  = s_inm ? w_imm : w_alu;

  always_ff @(posedge clk) begin
    if (we3 && (w_wa3 != '0)) r_rf[w_wa3] <= w_wd3;
  end

  assign w_pc_inc = r_pc + AW'(1);

  ras_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_din   (w_pc_inc),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  // A return on an empty stack falls through to the next instruction.
  always_comb begin
    w_pc_nxt = s_inc ? w_pc_inc : w_target;
    if (pop) w_pc_nxt = w_empty ? w_pc_inc : w_top;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_z   <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_err <= r_err | w_ovf | w_unf;
      if (wez) r_z <= w_zalu;
    end
  end

  assign pc        = r_pc;
  assign opcode    = instr[IW-1 -: OPC_W];
  assign z         = r_z;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_err   = r_err;

endmodule

// File: tb/tb_microc_ras.sv
// Scoreboard bench for microc_ras: stimulus pushes expected architectural
// state from a queue-based reference model; a monitor pops and compares.
module tb_microc_ras;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          s_inc = 1'b1, s_inm = 1'b0, we3 = 1'b0, wez = 1'b0;
  logic [2:0]    op = 3'b000;
  logic          push = 1'b0, pop = 1'b0;
  wire  [AW-1:0] pc;
  wire  [5:0]    opcode;
  wire           z, ras_empty, ras_full, ras_err;

  microc_ras #(.AW(AW), .DW(DW), .IW(IW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .s_inc(s_inc), .s_inm(s_inm),
    .we3(we3), .wez(wez), .op(op), .push(push), .pop(pop), .pc(pc),
    .opcode(opcode), .z(z), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int opc;
    bit z;
    bit empty;
    bit full;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  // Reference model: architectural state only
  int m_pc;
  int m_regs[16];
  bit m_z, m_err;
  int m_stk[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int alu_ref(input int o, input int a, input int b);
    int r;
    case (o)
      0: r = a;
      1: r = ~a;
      2: r = a + b;
      3: r = a - b;
      4: r = a & b;
      5: r = a | b;
      6: r = -a;
      default: r = -b;
    endcase
    return r & ((1 << DW) - 1);
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_z   = 0;
    m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_edge(input bit rv, input int ins, input bit inc, inm, we, wz,
                            input int o, input bit ph, pp);
    int a, b, res, imm, nxt, wa;
    a   = ((ins >> 8) & 15) == 0 ? 0 : m_regs[(ins >> 8) & 15];
    b   = ((ins >> 4) & 15) == 0 ? 0 : m_regs[(ins >> 4) & 15];
    wa  = ins & 15;
    imm = (ins >> 4) & ((1 << DW) - 1);
    res = alu_ref(o, a, b);
    if (we && wa != 0) m_regs[wa] = inm ? imm : res;
    if (!rv) begin
      model_reset();
      return;
    end
    if (wz) m_z = (res == 0);
    nxt = (m_pc + 1) % (1 << AW);
    if (pp) begin
      if (m_stk.size() > 0) begin
        int top = m_stk[m_stk.size() - 1];
        if (ph) m_stk[m_stk.size() - 1] = nxt;
        else void'(m_stk.pop_back());
        nxt = top;
      end else begin
        m_err = 1;
      end
    end else begin
      if (ph) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
        else m_err = 1;
      end
      if (!inc) nxt = ins & ((1 << AW) - 1);
    end
    m_pc = nxt;
  endtask

  function automatic exp_t snap(input int ins);
    exp_t e;
    e.pc    = m_pc;
    e.opc   = (ins >> 10) & 63;
    e.z     = m_z;
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.err   = m_err;
    return e;
  endfunction

  task automatic step(input bit rv, input int ins, input bit inc, inm, we, wz,
                      input int o, input bit ph, pp);
    bit mid_rst;
    @(negedge clk);
    mid_rst = (!rv && reset);
    reset = rv; instr = ins[IW-1:0]; s_inc = inc; s_inm = inm;
    we3 = we; wez = wz; op = o[2:0]; push = ph; pop = pp;
    if (mid_rst) begin
      model_reset();
      sb.push_back(snap(ins));
      ->chk_ev;
      #2;
    end
    model_edge(rv, ins, inc, inm, we, wz, o, ph, pp);
    sb.push_back(snap(ins));
  endtask

  task automatic nop();                      step(1, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic rst_cyc();                  step(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input int t);           step(1, t, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic call(input int t);          step(1, t, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic ret();                      step(1, 0, 1, 0, 0, 0, 0, 0, 1); endtask
  task automatic tail(input int t);          step(1, t, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic ldi(input int r, input int v); step(1, (v << 4) | r, 1, 1, 1, 0, 0, 0, 0); endtask
  task automatic alu(input int o, input int a, input int b, input int d, input bit wz);
    step(1, (a << 8) | (b << 4) | d, 1, 0, 1, wz, o, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("pc",        32'(pc),        32'(e.pc));
        cmp("opcode",    32'(opcode),    32'(e.opc));
        cmp("z",         32'(z),         32'(e.z));
        cmp("ras_empty", 32'(ras_empty), 32'(e.empty));
        cmp("ras_full",  32'(ras_full),  32'(e.full));
        cmp("ras_err",   32'(ras_err),   32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    // reset state, then sequential fetch
    rst_cyc(); rst_cyc();
    nop(); nop(); nop();
    // register file, ALU, Z flag, r0
    ldi(1, 8'h05); ldi(2, 8'h03);
    alu(3, 1, 2, 3, 1);
    ldi(4, 8'h02);
    alu(3, 3, 4, 5, 1);
    alu(2, 1, 2, 7, 1);
    alu(3, 1, 1, 6, 1);
    alu(2, 1, 2, 9, 1);
    ldi(0, 8'hAA);
    alu(0, 0, 0, 8, 1);
    // nested calls
    jmp(10); call(40); call(80); ret(); ret(); nop();
    // tail call with one entry
    jmp(19); call(30); tail(55); ret(); nop();
    // overflow and LIFO unwinding
    rst_cyc(); nop();
    call(100); call(200); call(300); call(400); call(500);
    ret(); ret(); ret(); ret(); nop();
    // underflow, sticky error
    rst_cyc(); jmp(7); ret(); nop(); nop(); tail(3); nop();
    // PC wrap
    jmp((1 << AW) - 1); nop(); nop();
    // reset asserted between edges with live state
    ldi(1, 8'h05); alu(3, 1, 1, 2, 1); call(60); call(70);
    rst_cyc(); rst_cyc(); nop(); nop();
    // random traffic over initialised registers
    for (int r = 1; r < 16; r++) ldi(r, $urandom_range(0, 255));
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) != 0, int'($urandom_range(0, 65535)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    nop();
    @(negedge clk);
    @(negedge clk);
    cmp("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
